// File: rtl/adpll_cfg_regs_pkg.sv
// Shared definitions for the ADPLL configuration register bank.
// Contents: FCW/accumulator widths, the adpll_mode encoding, register word
// addresses, CTRL and STATUS bit positions and the lock-supervisor state
// encoding (also visible to software through STATUS[5:4]).
package adpll_cfg_regs_pkg;

  localparam int FCWW = 26;           // frequency control word width
  localparam int INTW = 8;            // integer part of the FCW
  localparam int FRAW = FCWW - INTW;  // fractional part of the FCW
  localparam int ACCW = 32;           // phase accumulator width in the core

  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } adpll_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } lock_state_e;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_FCW       = 3'd1;
  localparam logic [2:0] ADDR_LOOP      = 3'd2;
  localparam logic [2:0] ADDR_TEST      = 3'd3;
  localparam logic [2:0] ADDR_STATUS    = 3'd4;
  localparam logic [2:0] ADDR_LOCK_TIME = 3'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_APPLY   = 3;
  localparam int CTRL_IRQ_EN  = 4;

  localparam int STAT_LIVE      = 0;
  localparam int STAT_LOCK_DONE = 1;
  localparam int STAT_TIMEOUT   = 2;
  localparam int STAT_LOCK_LOST = 3;
  localparam int STAT_STATE_LO  = 4;

  // Only the radio modes run the loop, so only they need lock supervision.
  function automatic logic mode_needs_lock(input logic [1:0] mode);
    return (mode == MODE_RX) || (mode == MODE_TX);
  endfunction

endpackage

// File: rtl/adpll_lock_timer.sv
// Lock-acquisition timer for the ADPLL supervisor.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           apply strobe: clears the counter and the captured time
//   i_en              controller enable; low freezes the counter
//   i_run             supervisor is waiting for lock
//   i_lock            channel_lock from the controller
//   o_lock_hit        lock accepted this cycle (combinational)
//   o_timeout_hit     timeout reached this cycle without lock (combinational)
//   o_lock_time       counter value captured at lock, saturating at 0xFFFF
module adpll_lock_timer #(
  parameter int LOCK_TIMEOUT = 4096,
  parameter int BLANK        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_en,
  input  logic        i_run,
  input  logic        i_lock,
  output logic        o_lock_hit,
  output logic        o_timeout_hit,
  output logic [15:0] o_lock_time
);

  localparam logic [15:0] BLANK_C        = 16'(BLANK);
  localparam logic [15:0] TIMEOUT_LAST_C = 16'(LOCK_TIMEOUT - 1);

  logic [15:0] r_cnt;
  logic [15:0] r_lock_time;
  logic        w_active;

  // A fresh apply always wins over whatever the old run would have decided.
  assign w_active      = i_run & i_en & ~i_start;
  // The controller takes a couple of cycles to drop a stale lock, so early
  // lock indications are blanked.
  assign o_lock_hit    = w_active & i_lock & (r_cnt >= BLANK_C);
  // Lock has priority when both land in the same cycle.
  assign o_timeout_hit = w_active & ~o_lock_hit & (r_cnt == TIMEOUT_LAST_C);
  assign o_lock_time   = r_lock_time;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_lock_time <= '0;
    end else if (i_start) begin
      r_cnt       <= '0;
      r_lock_time <= '0;
    end else if (w_active) begin
      if (o_lock_hit) begin
        r_lock_time <= r_cnt;
      end else if (r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/adpll_cfg_regs.sv
// CPU register bank and channel-sequencing supervisor for the ADPLL core.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_sel, i_we, i_addr, i_wdata     single-cycle bus access
//   o_rdata, o_rvalid                registered read data, valid one cycle later
//   o_irq                            level interrupt (irq_en & any sticky status)
//   o_en, o_fcw, o_adpll_mode        enable and atomically applied FCW/mode
//   i_channel_lock                   lock indication from the controller
//   o_alpha_*, o_beta, o_lambda_*,
//   o_iir_n_*                        loop gains (LOOP register, direct)
//   o_fcw_mod, o_dco_*_test,
//   o_*_pd_test                      test words (TEST register, direct)
module adpll_cfg_regs
  import adpll_cfg_regs_pkg::*;
#(
  parameter int DW           = 32,
  parameter int FCWW         = adpll_cfg_regs_pkg::FCWW,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int BLANK        = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sel,
  input  logic            i_we,
  input  logic [2:0]      i_addr,
  input  logic [DW-1:0]   i_wdata,
  output logic [DW-1:0]   o_rdata,
  output logic            o_rvalid,
  output logic            o_irq,
  output logic            o_en,
  output logic [FCWW-1:0] o_fcw,
  output logic [1:0]      o_adpll_mode,
  input  logic            i_channel_lock,
  output logic [3:0]      o_alpha_l,
  output logic [3:0]      o_alpha_m,
  output logic [3:0]      o_alpha_s_rx,
  output logic [3:0]      o_alpha_s_tx,
  output logic [3:0]      o_beta,
  output logic [2:0]      o_lambda_rx,
  output logic [2:0]      o_lambda_tx,
  output logic [1:0]      o_iir_n_rx,
  output logic [1:0]      o_iir_n_tx,
  output logic [4:0]      o_fcw_mod,
  output logic [4:0]      o_dco_c_l_word_test,
  output logic [7:0]      o_dco_c_m_word_test,
  output logic [7:0]      o_dco_c_s_word_test,
  output logic            o_dco_pd_test,
  output logic            o_tdc_pd_test,
  output logic            o_tdc_pd_inj_test
);

  logic            r_en, r_irq_en;
  logic [1:0]      r_mode_shadow, r_mode;
  logic [FCWW-1:0] r_fcw_shadow, r_fcw;
  logic [29:0]     r_loop;
  logic [28:0]     r_test;
  lock_state_e     r_state;
  logic [2:0]      r_sticky;  // {lock_lost, timeout, lock_done}
  logic [DW-1:0]   r_rdata;
  logic            r_rvalid;

  logic            w_wr, w_rd, w_wr_ctrl, w_wr_status, w_apply;
  logic [1:0]      w_apply_mode;
  logic            w_lock_hit, w_timeout_hit, w_lost_hit;
  logic [15:0]     w_lock_time;
  logic [2:0]      w_sticky_set, w_sticky_next;
  logic [DW-1:0]   w_rd_data;
  logic [DW-31:0]  w_unused_wdata;

  assign w_wr         = i_sel & i_we;
  assign w_rd         = i_sel & ~i_we;
  assign w_wr_ctrl    = w_wr & (i_addr == ADDR_CTRL);
  assign w_wr_status  = w_wr & (i_addr == ADDR_STATUS);
  assign w_apply      = w_wr_ctrl & i_wdata[CTRL_APPLY];
  // The mode bits carried by the apply write itself are the ones applied.
  assign w_apply_mode = i_wdata[CTRL_MODE_LO +: 2];
  assign w_unused_wdata = i_wdata[DW-1:30];

  adpll_lock_timer #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .BLANK        (BLANK)
  ) u_lock_timer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (w_apply),
    .i_en          (r_en),
    .i_run         (r_state == ST_WAIT),
    .i_lock        (i_channel_lock),
    .o_lock_hit    (w_lock_hit),
    .o_timeout_hit (w_timeout_hit),
    .o_lock_time   (w_lock_time)
  );

  assign w_lost_hit   = (r_state == ST_LOCKED) & r_en & ~i_channel_lock & ~w_apply;
  assign w_sticky_set = {w_lost_hit, w_timeout_hit, w_lock_hit};

  // Sticky status bits: a hardware set in the same cycle as a W1C wins.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sticky
      assign w_sticky_next[gi] = w_sticky_set[gi] |
          (r_sticky[gi] & ~(w_wr_status & i_wdata[STAT_LOCK_DONE + gi]));
    end
  endgenerate

  always_comb begin
    w_rd_data = '0;
    case (i_addr)
      ADDR_CTRL: begin
        w_rd_data[CTRL_EN]             = r_en;
        w_rd_data[CTRL_MODE_LO +: 2]   = r_mode_shadow;
        w_rd_data[CTRL_IRQ_EN]         = r_irq_en;
      end
      ADDR_FCW:       w_rd_data[FCWW-1:0] = r_fcw_shadow;
      ADDR_LOOP:      w_rd_data[29:0]     = r_loop;
      ADDR_TEST:      w_rd_data[28:0]     = r_test;
      ADDR_STATUS: begin
        w_rd_data[STAT_LIVE]           = i_channel_lock;
        w_rd_data[STAT_LOCK_DONE +: 3] = r_sticky;
        w_rd_data[STAT_STATE_LO +: 2]  = r_state;
      end
      ADDR_LOCK_TIME: w_rd_data[15:0]     = w_lock_time;
      default: ;
    endcase
  end

  // Register file, apply path and bus read port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en          <= 1'b0;
      r_irq_en      <= 1'b0;
      r_mode_shadow <= '0;
      r_mode        <= MODE_PD;
      r_fcw_shadow  <= '0;
      r_fcw         <= '0;
      r_loop        <= '0;
      r_test        <= '0;
      r_sticky      <= '0;
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rd_data;
      r_sticky <= w_sticky_next;
      if (w_wr_ctrl) begin
        r_en          <= i_wdata[CTRL_EN];
        r_mode_shadow <= i_wdata[CTRL_MODE_LO +: 2];
        r_irq_en      <= i_wdata[CTRL_IRQ_EN];
      end
      if (w_wr && i_addr == ADDR_FCW)  r_fcw_shadow <= i_wdata[FCWW-1:0];
      if (w_wr && i_addr == ADDR_LOOP) r_loop       <= i_wdata[29:0];
      if (w_wr && i_addr == ADDR_TEST) r_test       <= i_wdata[28:0];
      // FCW and mode move together so the controller restarts only once.
      if (w_apply) begin
        r_fcw  <= r_fcw_shadow;
        r_mode <= w_apply_mode;
      end
    end
  end

  // Lock supervisor. With en low the controller is frozen, so is this.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else if (w_apply) begin
      r_state <= mode_needs_lock(w_apply_mode) ? ST_WAIT : ST_IDLE;
    end else if (r_en) begin
      case (r_state)
        ST_WAIT: begin
          if (w_lock_hit)         r_state <= ST_LOCKED;
          else if (w_timeout_hit) r_state <= ST_FAULT;
        end
        ST_LOCKED: if (!i_channel_lock) r_state <= ST_FAULT;
        default: ;  // IDLE and FAULT wait for the next apply
      endcase
    end
  end

  assign o_rdata      = r_rdata;
  assign o_rvalid     = r_rvalid;
  assign o_irq        = r_irq_en & (|r_sticky);
  assign o_en         = r_en;
  assign o_fcw        = r_fcw;
  assign o_adpll_mode = r_mode;

  assign o_alpha_l    = r_loop[3:0];
  assign o_alpha_m    = r_loop[7:4];
  assign o_alpha_s_rx = r_loop[11:8];
  assign o_alpha_s_tx = r_loop[15:12];
  assign o_beta       = r_loop[19:16];
  assign o_lambda_rx  = r_loop[22:20];
  assign o_lambda_tx  = r_loop[25:23];
  assign o_iir_n_rx   = r_loop[27:26];
  assign o_iir_n_tx   = r_loop[29:28];

  assign o_dco_c_l_word_test = r_test[4:0];
  assign o_dco_c_m_word_test = r_test[12:5];
  assign o_dco_c_s_word_test = r_test[20:13];
  assign o_dco_pd_test       = r_test[21];
  assign o_tdc_pd_test       = r_test[22];
  assign o_tdc_pd_inj_test   = r_test[23];
  assign o_fcw_mod           = r_test[28:24];

endmodule

// File: tb/tb_adpll_cfg_regs.sv
module tb_adpll_cfg_regs;

  logic        clk = 1'b0;
  logic        rst, sel, we, lock;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  logic        rvalid, irq, en;
  logic [25:0] fcw;
  logic [1:0]  mode;
  logic [3:0]  alpha_l, alpha_m, alpha_s_rx, alpha_s_tx, beta;
  logic [2:0]  lambda_rx, lambda_tx;
  logic [1:0]  iir_n_rx, iir_n_tx;
  logic [4:0]  fcw_mod, c_l;
  logic [7:0]  c_m, c_s;
  logic        dco_pd, tdc_pd, tdc_inj;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adpll_cfg_regs dut (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_rvalid(rvalid), .o_irq(irq),
    .o_en(en), .o_fcw(fcw), .o_adpll_mode(mode), .i_channel_lock(lock),
    .o_alpha_l(alpha_l), .o_alpha_m(alpha_m), .o_alpha_s_rx(alpha_s_rx),
    .o_alpha_s_tx(alpha_s_tx), .o_beta(beta), .o_lambda_rx(lambda_rx),
    .o_lambda_tx(lambda_tx), .o_iir_n_rx(iir_n_rx), .o_iir_n_tx(iir_n_tx),
    .o_fcw_mod(fcw_mod), .o_dco_c_l_word_test(c_l), .o_dco_c_m_word_test(c_m),
    .o_dco_c_s_word_test(c_s), .o_dco_pd_test(dco_pd), .o_tdc_pd_test(tdc_pd),
    .o_tdc_pd_inj_test(tdc_inj)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          osel;     // 1 LOOP outs, 2 TEST outs, 3 FCW out, 4 mode out
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] out_sel(input int s);
    case (s)
      1: return {2'b0, iir_n_tx, iir_n_rx, lambda_tx, lambda_rx, beta,
                 alpha_s_tx, alpha_s_rx, alpha_m, alpha_l};
      2: return {3'b0, fcw_mod, tdc_inj, tdc_pd, dco_pd, c_s, c_m, c_l};
      3: return {6'b0, fcw};
      default: return {30'b0, mode};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    $display("WR addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    $display("RD addr=%0d data=0x%08h rvalid=%0b (%s)", a, rdata, rvalid, name);
    check({name, " rvalid"}, {31'b0, rvalid}, 32'd1);
    check(name, rdata, exp);
    @(negedge clk);
    check({name, " rvalid drop"}, {31'b0, rvalid}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; lock = 1'b0;

    vecs[0]  = '{3'd2, 32'hFFFF_FFFF, 32'h3FFF_FFFF, 1, 32'h3FFF_FFFF};
    vecs[1]  = '{3'd2, 32'h1234_5678, 32'h1234_5678, 1, 32'h1234_5678};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'h1FFF_FFFF, 2, 32'h1FFF_FFFF};
    vecs[3]  = '{3'd3, 32'h0A5A_5A5A, 32'h0A5A_5A5A, 2, 32'h0A5A_5A5A};
    vecs[4]  = '{3'd1, 32'hFFFF_FFFF, 32'h03FF_FFFF, 3, 32'h0000_0000};
    vecs[5]  = '{3'd1, 32'h00A1_C000, 32'h00A1_C000, 3, 32'h0000_0000};
    vecs[6]  = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0000, 2, 32'h0A5A_5A5A};
    vecs[7]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'h1234_5678};
    vecs[8]  = '{3'd0, 32'h0000_0015, 32'h0000_0015, 4, 32'h0000_0000};
    vecs[9]  = '{3'd0, 32'h0000_0006, 32'h0000_0006, 4, 32'h0000_0000};
    vecs[10] = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0000, 4, 32'h0000_0000};
    vecs[11] = '{3'd5, 32'h0000_FFFF, 32'h0000_0000, 3, 32'h0000_0000};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset outputs", {31'b0, |{en, fcw, mode, irq, rvalid, rdata, out_sel(1), out_sel(2)}}, 32'd0);
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("reset rd%0d", a));

    // Register vectors
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d out", i), out_sel(vecs[i].osel), vecs[i].exp_out);
      rd(vecs[i].addr, vecs[i].exp_rd, $sformatf("vec%0d rd", i));
      if (i == 1) begin
        check("alpha_s_rx field", {28'b0, alpha_s_rx}, 32'h6);
        check("beta field", {28'b0, beta}, 32'h4);
        check("lambda_rx field", {29'b0, lambda_rx}, 32'h3);
      end
      if (i == 3) begin
        check("c_l field", {27'b0, c_l}, 32'h1A);
        check("c_m field", {24'b0, c_m}, 32'hD2);
        check("fcw_mod field", {27'b0, fcw_mod}, 32'h0A);
      end
    end

    // Shadow writes without apply, then atomic apply
    wr(3'd1, 32'h00A1_C000);
    wr(3'd0, 32'h0000_0005);
    check("fcw before apply", {6'b0, fcw}, 32'h0);
    check("mode before apply", {30'b0, mode}, 32'h0);
    wr(3'd0, 32'h0000_000D);
    check("fcw on apply", {6'b0, fcw}, 32'h00A1_C000);
    check("mode on apply", {30'b0, mode}, 32'h2);
    rd(3'd4, 32'h10, "status wait");
    rd(3'd0, 32'h05, "ctrl apply reads 0");

    // Blanked early lock, then lock at cycle 600
    wr(3'd0, 32'h0000_001D);
    repeat (2) @(negedge clk);
    lock = 1'b1;
    @(negedge clk);
    lock = 1'b0;
    repeat (597) @(negedge clk);
    check("irq before lock", {31'b0, irq}, 32'd0);
    lock = 1'b1;
    @(negedge clk);
    check("irq at lock", {31'b0, irq}, 32'd1);
    rd(3'd4, 32'h23, "status locked");
    rd(3'd5, 32'd600, "lock_time 600");

    // Lock lost, fault holds through re-lock
    lock = 1'b0;
    @(negedge clk);
    rd(3'd4, 32'h3A, "status lock lost");
    lock = 1'b1;
    repeat (5) @(negedge clk);
    rd(3'd4, 32'h3B, "status fault holds");

    // Re-apply with lock already high: accepted at the blanking boundary
    wr(3'd0, 32'h0000_001D);
    repeat (10) @(negedge clk);
    rd(3'd4, 32'h2B, "status relocked");
    rd(3'd5, 32'd4, "lock_time blank");

    // W1C of lock_lost in the same cycle as a new lock_lost set
    @(negedge clk);
    lock = 1'b0; sel = 1'b1; we = 1'b1; addr = 3'd4; wdata = 32'h08;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    $display("WR addr=4 data=0x00000008 (collides with lock loss)");
    rd(3'd4, 32'h3A, "status set beats w1c");
    wr(3'd4, 32'h0000_000A);
    rd(3'd4, 32'h30, "status w1c cleared");
    check("irq after w1c", {31'b0, irq}, 32'd0);

    // Timeout at cycle 4095
    wr(3'd0, 32'h0000_001D);
    repeat (4095) @(negedge clk);
    check("irq before timeout", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq at timeout", {31'b0, irq}, 32'd1);
    rd(3'd4, 32'h34, "status timeout");
    rd(3'd5, 32'd0, "lock_time after timeout");
    wr(3'd4, 32'h0000_0004);
    check("irq timeout cleared", {31'b0, irq}, 32'd0);
    rd(3'd4, 32'h30, "status timeout cleared");

    // en=0 freezes the wait: no timeout
    wr(3'd0, 32'h0000_001C);
    repeat (4200) @(negedge clk);
    check("irq frozen", {31'b0, irq}, 32'd0);
    rd(3'd4, 32'h10, "status frozen wait");

    // TEST mode apply goes to IDLE
    wr(3'd0, 32'h0000_000B);
    check("mode test", {30'b0, mode}, 32'h1);
    check("test outs", out_sel(2), 32'h0A5A_5A5A);
    rd(3'd4, 32'h00, "status idle test");

    // Reset in the middle of WAIT
    wr(3'd0, 32'h0000_001D);
    repeat (3) @(negedge clk);
    rd(3'd4, 32'h10, "status wait pre-reset");
    rst = 1'b1;
    @(negedge clk);
    check("outputs after reset", {31'b0, |{en, fcw, mode, irq, rvalid, rdata, out_sel(1), out_sel(2)}}, 32'd0);
    rst = 1'b0;
    rd(3'd4, 32'h00, "status after reset");
    rd(3'd1, 32'h00, "fcw shadow after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adpll_cfg_regs.md
Name: adpll_cfg_regs

Overview:
CPU-side register bank and channel-sequencing supervisor for the ADPLL core controller.
- Holds shadow copies of FCW, mode, loop gains and test words.
- Applies them atomically to the controller, so FCW and adpll_mode change in the same cycle and the controller restarts only once.
- Times the lock acquisition, flags timeout and lock loss, and raises an interrupt.
- Sits between the CPU bus and the controller's external-register inputs.

Parameters:
- DW, 32, CPU data width.
- FCWW, 26, FCW width (matches shared FCW width constant).
- LOCK_TIMEOUT, 4096, cycles from apply to lock before timeout is declared.
- BLANK, 4, cycles after apply during which channel_lock is ignored (controller needs 2 cycles to clear it).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  bus access strobe, one-cycle.
- we  in  1  1=write, 0=read; sampled with sel.
- addr  in  3  word address.
- wdata  in  DW  write data.
- rdata  out  DW  read data, registered.
- rvalid  out  1  one-cycle pulse, 1 cycle after a read sel.
- irq  out  1  level interrupt.
- en  out  1  controller enable.
- FCW  out  FCWW  active FCW.
- adpll_mode  out  2  active mode: PD=0, TEST=1, RX=2, TX=3.
- channel_lock  in  1  from controller.
- alpha_l, alpha_m, alpha_s_rx, alpha_s_tx, beta  out  4 each  loop gains.
- lambda_rx, lambda_tx  out  3 each.
- iir_n_rx, iir_n_tx  out  2 each.
- FCW_mod  out  5.
- dco_c_l_word_test  out  5.
- dco_c_m_word_test, dco_c_s_word_test  out  8 each.
- dco_pd_test, tdc_pd_test, tdc_pd_inj_test  out  1 each.

Behaviour:
Register map (unlisted bits read 0):
- 0 CTRL: [0] en (direct, immediate), [2:1] mode shadow, [3] apply (write-1 strobe, reads 0), [4] irq_en.
- 1 FCW shadow [25:0].
- 2 LOOP: alpha_l[3:0], alpha_m[7:4], alpha_s_rx[11:8], alpha_s_tx[15:12], beta[19:16], lambda_rx[22:20], lambda_tx[25:23], iir_n_rx[27:26], iir_n_tx[29:28]. Direct, takes effect next cycle.
- 3 TEST: c_l[4:0], c_m[12:5], c_s[20:13], dco_pd_test[21], tdc_pd_test[22], tdc_pd_inj_test[23], FCW_mod[28:24]. Direct.
- 4 STATUS:
  - [0] channel_lock live, RO.
  - [1] lock_done, W1C.
  - [2] timeout, W1C.
  - [3] lock_lost, W1C.
  - [5:4] FSM state, RO.
- 5 LOCK_TIME: [15:0] cycles from apply to lock rise, saturates at 0xFFFF, RO.
- 6–7 reserved: writes ignored, reads 0.

Reset values:
- All outputs and registers 0.
- adpll_mode=PD, so the controller powers down.
- rvalid=0, irq=0, FSM=IDLE.

Apply:
- Writing CTRL with bit3=1 copies FCW shadow and mode shadow to FCW/adpll_mode on the same edge.
- The other CTRL bits in that write take effect on the same edge.

FSM states: IDLE, WAIT, LOCKED, FAULT.
- Any apply, from any state: counter=0, LOCK_TIME=0. Next state is WAIT if the applied mode is RX or TX, otherwise IDLE.
- WAIT:
  - Counter increments each cycle; channel_lock is ignored while counter<BLANK.
  - channel_lock=1 with counter≥BLANK → LOCKED, LOCK_TIME=counter, lock_done set.
  - counter==LOCK_TIMEOUT-1 without lock → FAULT, timeout set.
  - Lock and timeout in the same cycle: lock wins.
- LOCKED: channel_lock falls → FAULT, lock_lost set.
- FAULT: holds until the next apply; channel_lock re-rising does not exit.
- en=0 freezes the FSM and counter. The controller is also frozen, so no false timeout.

Bus:
- Read data is registered: rdata and rvalid are valid 1 cycle after sel&!we. rdata holds its value otherwise.
- W1C write colliding with a hardware set of the same bit in the same cycle: the set wins.
- Writes to shadows during WAIT do not disturb outputs.
- irq = irq_en & (lock_done|timeout|lock_lost).

Reset mid-WAIT: immediate return to reset values on the next edge; no sticky bits survive.

Decomposition:
- Shared package (adpll_defines): FCWW/ACCW/INTW/FRAW widths, mode encodings PD/TEST/RX/TX, register address constants, STATUS bit indices, FSM state encoding.
- One natural sub-module: adpll_lock_timer (counter, blanking, saturation, timeout compare) with inputs start/en/lock and outputs locked/timeout/lock_time.

Test Plan:
- Reset: read all 8 addresses → all 0, adpll_mode=0, irq=0, rvalid high exactly 1 cycle after each read.
- Write FCW=0x0A1C000, CTRL=0x05 (en=1, mode=RX via shadow) without apply → FCW/mode outputs unchanged. Then write CTRL=0x0D → FCW and adpll_mode=2 change on the same edge; STATUS[5:4]=WAIT.
- After apply, pulse channel_lock at cycle 2 then hold it high from cycle 600 → ignored at cycle 2, LOCKED at 600, LOCK_TIME=600, lock_done=1, irq=1 with irq_en=1.
- Apply RX and keep channel_lock=0 → timeout set at cycle 4095, state FAULT; W1C STATUS bit2 → clears, irq drops.
- From LOCKED, drop channel_lock → lock_lost=1, FAULT. W1C bit3 in the same cycle a second set occurs → bit remains 1.
- Apply mode TEST → state IDLE, TEST register fields reach outputs; assert rst mid-WAIT → all outputs 0 on the next edge.
